rename_freelist: RTL and testbench
==================================

# rename_freelist

Parametrised physical-register free list for the rename stage, generalising the fixed 64-entry, 4-lane freelist. It hands out free physical indices to up to ALLOC_W rename lanes per cycle, accepts up to RLS_W releases from retire, and keeps a committed head pointer so a pipeline flush reclaims every speculative allocation in one cycle. It sits between the rename map table and the ROB retire path.

## Interface
- NUM_PREG, 64, physical registers; NUM_PREG > NUM_ARCH.
- NUM_ARCH, 32, architectural registers, initially mapped to pidx 0..NUM_ARCH-1.
- ALLOC_W, 4, allocation lanes.
- RLS_W, 4, release lanes.
- PIDX_W, $clog2(NUM_PREG), derived, not overridden.
- D = NUM_PREG-NUM_ARCH, FIFO depth, derived; CNT_W = $clog2(D+1).

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- io_req  in  ALLOC_W  per-lane allocation request; any bit pattern.
- io_pidx  out  ALLOC_W*PIDX_W  allocated index per lane, lane i at bits [i*PIDX_W +: PIDX_W].
- io_pvld  out  ALLOC_W  lane i granted.
- io_busy  out  1  request set not granted this cycle.
- io_rls  in  RLS_W  per-lane release valid.
- io_rls_pidx  in  RLS_W*PIDX_W  released indices.
- io_commit_cnt  in  $clog2(ALLOC_W+1)  allocations becoming non-speculative.
- io_flush  in  1  discard all speculative allocations.
- io_free_cnt  out  CNT_W  speculative free count.
- io_err  out  1  sticky protocol-error flag.

## Operation
- Storage: circular array of D entries of PIDX_W; registers spec_head, cmt_head, tail (mod D), spec_cnt, cmt_cnt (CNT_W).
- Reset: entry[i] = NUM_ARCH+i; spec_head = cmt_head = tail = 0; spec_cnt = cmt_cnt = D; io_err = 0.
- n_req = popcount(io_req). Grant iff n_req <= spec_cnt and !io_flush: all-or-nothing. On grant, io_pvld = io_req and lane i reads entry[(spec_head + number of set req bits below i) mod D]; spec_head += n_req, spec_cnt -= n_req. Otherwise io_pvld = 0, no state change. n_req = 0 is never busy.
- io_busy = (n_req > spec_cnt) | io_flush, and is independent of whether io_req is zero when io_flush is asserted.
- Release: lanes are compacted the same way; entry[(tail + offset) mod D] = io_rls_pidx; tail += n_rls; spec_cnt and cmt_cnt += n_rls. If cmt_cnt + n_rls > D, no entry is written, counts are unchanged and io_err is set.
- Commit: cmt_head += io_commit_cnt; cmt_cnt -= io_commit_cnt. If io_commit_cnt > (cmt_cnt - spec_cnt), meaning more than the outstanding speculative allocations, the commit is ignored and io_err is set.
- Flush: spec_head <= cmt_head_next, spec_cnt <= cmt_cnt_next. Same-cycle commit and release are applied before the flush copy.
- Pointer arithmetic: ptr + k with k <= max(ALLOC_W,RLS_W) <= D uses one conditional subtraction of D. D need not be a power of two.
- io_err clears only on reset.

## Timing
- io_pidx, io_pvld, io_busy and io_free_cnt are combinational from registered state plus io_req/io_flush. There is no input-to-register latency on grant.
- State updates on the rising edge. Released entries become allocatable the next cycle; there is no same-cycle release-to-alloc bypass.
- While reset is low, io_pvld = 0, io_busy = 0, io_free_cnt = D, io_err = 0, and io_pidx lanes equal NUM_ARCH + lane offset (don't-care for checking). Reset asserted mid-operation restores the full initial list immediately.
- Full list (spec_cnt = D): allocation proceeds normally; any release sets io_err.
- Empty list: any nonzero request is busy.
- Wrap: allocations and releases spanning entry D-1 to entry 0 are contiguous modulo D.

## Structure
- freelist_pkg: PIDX_W/CNT_W helper functions and a popcount function.
- Sub-module freelist_compact #(W): input valid vector, output per-lane prefix offsets and total count. It is instantiated once for the allocation side and once for the release side.
- The top level contains the entry array, pointers, counters and error logic.

## Test plan
- Reset release, no requests -> io_free_cnt = 32, io_pvld = 0, io_busy = 0, io_err = 0.
- io_req = 4'b1101 held from the first cycle -> cycle 0 lanes 0/2/3 get pidx 32/33/34, cycle 1 gets 35/36/37; after 10 cycles io_busy = 1, io_pvld = 0, io_free_cnt = 2.
- Exhaust the list, then release 0,1,2,3 in one cycle -> the next cycle io_req = 4'b0011 yields pidx 0 and 1 (wrapped entries), io_free_cnt goes 4 -> 2.
- Allocate 6, commit 2, then assert io_flush -> the next cycle io_free_cnt = 30 and the next grant returns pidx 34.
- Commit 4 with a flush in the same cycle after 5 allocations -> io_free_cnt = 28; release with cmt_cnt = D -> io_err = 1 and stays 1.
- Assert reset mid-stream -> io_free_cnt = 32 at once and the first post-reset grant returns pidx 32.

Source files
------------

// File: rtl/rename_freelist_pkg.sv
// Shared helpers for the rename free list: width derivation and popcount.
package freelist_pkg;

    // Index width for a table of n entries (at least one bit).
    function automatic int pidx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..d inclusive.
    function automatic int cnt_width(input int d);
        return (d > 0) ? $clog2(d + 1) : 1;
    endfunction

    // Number of set bits in a vector of up to 32 lanes.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rename_freelist_compact.sv
// Lane compaction: for each valid lane, how many valid lanes sit below it,
// plus the total number of valid lanes. Used to pack sparse requests onto
// consecutive free-list entries. Supports up to 32 lanes.
module freelist_compact
    import freelist_pkg::*;
#(
    parameter int W = 4,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]          valid,
    output logic [W-1:0][OW-1:0]  offs,
    output logic [OW-1:0]         cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            logic [W-1:0] below_mask;
            assign below_mask = W'((64'd1 << gi) - 64'd1);
            assign offs[gi]   = OW'(popcount(32'(valid & below_mask)));
        end
    endgenerate

    assign cnt = OW'(popcount(32'(valid)));

endmodule

// File: rtl/rename_freelist.sv
// Physical-register free list for rename. A circular FIFO of free indices
// with a speculative head (advanced by allocation) and a committed head
// (advanced by commit); a flush snaps the speculative head back to the
// committed one, returning every uncommitted allocation in one cycle.
module rename_freelist
    import freelist_pkg::*;
#(
    parameter int NUM_PREG = 64,
    parameter int NUM_ARCH = 32,
    parameter int ALLOC_W  = 4,
    parameter int RLS_W    = 4,
    localparam int PIDX_W  = pidx_width(NUM_PREG),
    localparam int D       = NUM_PREG - NUM_ARCH,
    localparam int CNT_W   = cnt_width(D),
    localparam int CMT_W   = cnt_width(ALLOC_W)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ALLOC_W-1:0]        io_req,
    output logic [ALLOC_W*PIDX_W-1:0] io_pidx,
    output logic [ALLOC_W-1:0]        io_pvld,
    output logic                      io_busy,
    input  logic [RLS_W-1:0]          io_rls,
    input  logic [RLS_W*PIDX_W-1:0]   io_rls_pidx,
    input  logic [CMT_W-1:0]          io_commit_cnt,
    input  logic                      io_flush,
    output logic [CNT_W-1:0]          io_free_cnt,
    output logic                      io_err
);

    localparam int PTR_W = pidx_width(D);
    localparam int AOW   = cnt_width(ALLOC_W);
    localparam int ROW   = cnt_width(RLS_W);

    // Advance a pointer by k (k <= D); a single wrap is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [PTR_W:0]   k);
        logic [PTR_W:0] s;
        s = {1'b0, ptr} + k;
        if (s >= (PTR_W+1)'(D)) begin
            s = s - (PTR_W+1)'(D);
        end
        return s[PTR_W-1:0];
    endfunction

    logic [PIDX_W-1:0] entry_mem [D];
    logic [PTR_W-1:0]  spec_head_reg, cmt_head_reg, tail_reg;
    logic [PTR_W-1:0]  spec_head_next, cmt_head_next, tail_next;
    logic [CNT_W-1:0]  spec_cnt_reg, cmt_cnt_reg;
    logic [CNT_W-1:0]  spec_cnt_next, cmt_cnt_next;
    logic              err_reg;

    logic [ALLOC_W-1:0][AOW-1:0] alloc_off;
    logic [AOW-1:0]              n_req;
    logic [RLS_W-1:0][ROW-1:0]   rls_off;
    logic [ROW-1:0]              n_rls;

    logic [CNT_W-1:0] n_req_ext, n_rls_ext, commit_ext, outstanding;
    logic [CNT_W:0]   rls_sum;
    logic             grant, rls_ok, cmt_ok;

    logic [PTR_W-1:0] rd_ptr [ALLOC_W];
    logic [PTR_W-1:0] wr_ptr [RLS_W];

    freelist_compact #(.W(ALLOC_W)) u_alloc_compact (
        .valid (io_req),
        .offs  (alloc_off),
        .cnt   (n_req)
    );

    freelist_compact #(.W(RLS_W)) u_rls_compact (
        .valid (io_rls),
        .offs  (rls_off),
        .cnt   (n_rls)
    );

    assign n_req_ext   = CNT_W'(n_req);
    assign n_rls_ext   = CNT_W'(n_rls);
    assign commit_ext  = CNT_W'(io_commit_cnt);
    assign outstanding = cmt_cnt_reg - spec_cnt_reg;

    // All-or-nothing grant; outputs are forced idle while reset is held.
    assign grant   = reset && !io_flush && (n_req_ext <= spec_cnt_reg);
    assign io_pvld = grant ? io_req : '0;
    assign io_busy = reset && ((n_req_ext > spec_cnt_reg) || io_flush);

    // A release overflowing the committed count is a protocol error.
    assign rls_sum = {1'b0, cmt_cnt_reg} + (CNT_W+1)'(n_rls);
    assign rls_ok  = (rls_sum <= (CNT_W+1)'(D));
    // Committing more than is speculatively outstanding is a protocol error.
    assign cmt_ok  = (commit_ext <= outstanding);

    assign io_free_cnt = spec_cnt_reg;
    assign io_err      = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ALLOC_W; gi++) begin : g_rd
            assign rd_ptr[gi] = ptr_add(spec_head_reg, (PTR_W+1)'(alloc_off[gi]));
            assign io_pidx[gi*PIDX_W +: PIDX_W] = entry_mem[rd_ptr[gi]];
        end
        for (gi = 0; gi < RLS_W; gi++) begin : g_wr
            assign wr_ptr[gi] = ptr_add(tail_reg, (PTR_W+1)'(rls_off[gi]));
        end
    endgenerate

    // Next pointers/counts: allocate, release, commit, then flush copies committed state.
    always_comb begin
        spec_head_next = spec_head_reg;
        cmt_head_next  = cmt_head_reg;
        tail_next      = tail_reg;
        spec_cnt_next  = spec_cnt_reg;
        cmt_cnt_next   = cmt_cnt_reg;
        if (grant) begin
            spec_head_next = ptr_add(spec_head_reg, (PTR_W+1)'(n_req));
            spec_cnt_next  = spec_cnt_reg - n_req_ext;
        end
        if (rls_ok) begin
            tail_next     = ptr_add(tail_reg, (PTR_W+1)'(n_rls));
            spec_cnt_next = spec_cnt_next + n_rls_ext;
            cmt_cnt_next  = cmt_cnt_reg + n_rls_ext;
        end
        if (cmt_ok) begin
            cmt_head_next = ptr_add(cmt_head_reg, (PTR_W+1)'(io_commit_cnt));
            cmt_cnt_next  = cmt_cnt_next - commit_ext;
        end
        if (io_flush) begin
            spec_head_next = cmt_head_next;
            spec_cnt_next  = cmt_cnt_next;
        end
    end

    // State registers and entry array; reset restores the initial free list.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) begin
                entry_mem[i] <= PIDX_W'(NUM_ARCH + i);
            end
            spec_head_reg <= '0;
            cmt_head_reg  <= '0;
            tail_reg      <= '0;
            spec_cnt_reg  <= CNT_W'(D);
            cmt_cnt_reg   <= CNT_W'(D);
            err_reg       <= 1'b0;
        end else begin
            for (int i = 0; i < RLS_W; i++) begin
                if (rls_ok && io_rls[i]) begin
                    entry_mem[wr_ptr[i]] <= io_rls_pidx[i*PIDX_W +: PIDX_W];
                end
            end
            spec_head_reg <= spec_head_next;
            cmt_head_reg  <= cmt_head_next;
            tail_reg      <= tail_next;
            spec_cnt_reg  <= spec_cnt_next;
            cmt_cnt_reg   <= cmt_cnt_next;
            err_reg       <= err_reg | ~rls_ok | ~cmt_ok;
        end
    end

endmodule

// File: tb/tb_rename_freelist.sv
// Self-checking bench for rename_freelist: a reference model predicts each
// cycle's outputs, pushes them to a scoreboard, and they are popped and
// compared against the DUT just after the inputs settle.
module tb_rename_freelist;

    localparam int NA = 32;
    localparam int AW = 4;
    localparam int RW = 4;
    localparam int PW = 6;
    localparam int D  = 32;
    localparam int CW = 6;
    localparam int MW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     io_req;
    logic [AW*PW-1:0]  io_pidx;
    logic [AW-1:0]     io_pvld;
    logic              io_busy;
    logic [RW-1:0]     io_rls;
    logic [RW*PW-1:0]  io_rls_pidx;
    logic [MW-1:0]     io_commit_cnt;
    logic              io_flush;
    logic [CW-1:0]     io_free_cnt;
    logic              io_err;

    always #5 clock = ~clock;

    rename_freelist dut (
        .clock         (clock),
        .reset         (reset),
        .io_req        (io_req),
        .io_pidx       (io_pidx),
        .io_pvld       (io_pvld),
        .io_busy       (io_busy),
        .io_rls        (io_rls),
        .io_rls_pidx   (io_rls_pidx),
        .io_commit_cnt (io_commit_cnt),
        .io_flush      (io_flush),
        .io_free_cnt   (io_free_cnt),
        .io_err        (io_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0]    pvld;
        logic [AW*PW-1:0] pidx;
        logic [AW*PW-1:0] mask;
        logic             busy;
        logic [CW-1:0]    free;
        logic             err;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (plain integers, modulo arithmetic).
    int m_entry [D];
    int m_sh, m_ch, m_tl, m_sc, m_cc;
    bit m_err;

    // Last sampled DUT outputs, for directed checks against fixed values.
    logic [AW*PW-1:0] last_pidx;
    logic [AW-1:0]    last_pvld;
    logic             last_busy;
    logic [CW-1:0]    last_free;
    logic             last_err;

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_entry[i] = NA + i;
        m_sh = 0; m_ch = 0; m_tl = 0;
        m_sc = D; m_cc = D;
        m_err = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic step(input logic [AW-1:0] req, input logic flush, input logic [RW-1:0] rls,
                        input logic [RW*PW-1:0] rpidx, input int commit);
        exp_t e;
        exp_t got_e;
        int nreq, nrls, k;
        bit grant, rls_ok, cm_ok;
        io_req        = req;
        io_flush      = flush;
        io_rls        = rls;
        io_rls_pidx   = rpidx;
        io_commit_cnt = MW'(commit);

        nreq  = $countones(req);
        nrls  = $countones(rls);
        grant = !flush && (nreq <= m_sc);
        e.pvld = grant ? req : '0;
        e.busy = (nreq > m_sc) || flush;
        e.free = CW'(m_sc);
        e.err  = m_err;
        e.pidx = '0;
        e.mask = '0;
        k = 0;
        for (int i = 0; i < AW; i++) begin
            if (req[i]) begin
                if (grant) begin
                    e.pidx[i*PW +: PW] = PW'(m_entry[(m_sh + k) % D]);
                    e.mask[i*PW +: PW] = '1;
                end
                k++;
            end
        end
        sb_q.push_back(e);

        #1;
        got_e = sb_q.pop_front();
        last_pidx = io_pidx;
        last_pvld = io_pvld;
        last_busy = io_busy;
        last_free = io_free_cnt;
        last_err  = io_err;
        check("pvld", io_pvld, got_e.pvld);
        check("pidx", io_pidx & got_e.mask, got_e.pidx);
        check("busy", io_busy, got_e.busy);
        check("free_cnt", io_free_cnt, got_e.free);
        check("err", io_err, got_e.err);
        $display("t=%0t req=%b flush=%b rls=%b cmt=%0d -> pvld=%b pidx=%h busy=%b free=%0d err=%b",
                 $time, req, flush, rls, commit, io_pvld, io_pidx, io_busy, io_free_cnt, io_err);

        @(posedge clock);
        rls_ok = (m_cc + nrls) <= D;
        cm_ok  = commit <= (m_cc - m_sc);
        if (grant) begin
            m_sh = (m_sh + nreq) % D;
            m_sc = m_sc - nreq;
        end
        if (rls_ok) begin
            k = 0;
            for (int i = 0; i < RW; i++) begin
                if (rls[i]) begin
                    m_entry[(m_tl + k) % D] = int'(rpidx[i*PW +: PW]);
                    k++;
                end
            end
            m_tl = (m_tl + nrls) % D;
            m_sc = m_sc + nrls;
            m_cc = m_cc + nrls;
        end else begin
            m_err = 1;
        end
        if (cm_ok) begin
            m_ch = (m_ch + commit) % D;
            m_cc = m_cc - commit;
        end else begin
            m_err = 1;
        end
        if (flush) begin
            m_sh = m_ch;
            m_sc = m_cc;
        end
        @(negedge clock);
    endtask

    // Assert reset (with a live request to prove gating), check held outputs, release at a negedge.
    task automatic apply_reset();
        reset         = 1'b0;
        io_req        = '1;
        io_flush      = 1'b0;
        io_rls        = '0;
        io_rls_pidx   = '0;
        io_commit_cnt = '0;
        #1;
        check("rst_pvld", io_pvld, 0);
        check("rst_busy", io_busy, 0);
        check("rst_free", io_free_cnt, D);
        check("rst_err", io_err, 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        io_req = '0;
        reset  = 1'b1;
        $display("t=%0t reset released", $time);
    endtask

    initial begin
        reset         = 1'b1;
        io_req        = '0;
        io_flush      = 1'b0;
        io_rls        = '0;
        io_rls_pidx   = '0;
        io_commit_cnt = '0;
        #2;
        apply_reset();

        // Idle after reset.
        step('0, 0, '0, '0, 0);
        check("idle_free", last_free, 32);
        check("idle_pvld", last_pvld, 0);
        check("idle_busy", last_busy, 0);
        check("idle_err", last_err, 0);

        // Sparse request held until the list runs short.
        for (int c = 0; c <= 10; c++) begin
            step(4'b1101, 0, '0, '0, 0);
            if (c == 0) begin
                check("c0_lane0", last_pidx[0*PW +: PW], 32);
                check("c0_lane2", last_pidx[2*PW +: PW], 33);
                check("c0_lane3", last_pidx[3*PW +: PW], 34);
            end
            if (c == 1) begin
                check("c1_lane0", last_pidx[0*PW +: PW], 35);
                check("c1_lane3", last_pidx[3*PW +: PW], 37);
            end
        end
        check("short_busy", last_busy, 1);
        check("short_pvld", last_pvld, 0);
        check("short_free", last_free, 2);

        // Exhaust, then an empty list rejects any request.
        step(4'b0011, 0, '0, '0, 0);
        step(4'b0001, 0, '0, '0, 0);
        check("empty_busy", last_busy, 1);
        check("empty_free", last_free, 0);
        for (int c = 0; c < 8; c++) step('0, 0, '0, '0, 4);
        step('0, 0, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 0);
        step(4'b0011, 0, '0, '0, 0);
        check("wrap_lane0", last_pidx[0*PW +: PW], 0);
        check("wrap_lane1", last_pidx[1*PW +: PW], 1);
        check("wrap_free4", last_free, 4);
        step('0, 0, '0, '0, 0);
        check("wrap_free2", last_free, 2);
        check("wrap_err", last_err, 0);

        // Allocate 6, commit 2, flush.
        apply_reset();
        step(4'b1111, 0, '0, '0, 0);
        step(4'b0011, 0, '0, '0, 0);
        step('0, 0, '0, '0, 2);
        step('0, 1, '0, '0, 0);
        check("flush_busy", last_busy, 1);
        step('0, 0, '0, '0, 0);
        check("flush_free", last_free, 30);
        step(4'b0001, 0, '0, '0, 0);
        check("flush_pidx", last_pidx[0*PW +: PW], 34);

        // Commit 4 alongside a flush after 5 allocations; then overflow a release.
        apply_reset();
        step(4'b1111, 0, '0, '0, 0);
        step(4'b0001, 0, '0, '0, 0);
        step('0, 1, '0, '0, 4);
        step('0, 0, '0, '0, 0);
        check("cmtflush_free", last_free, 28);
        step('0, 0, 4'b1111, {6'd40, 6'd41, 6'd42, 6'd43}, 0);
        step('0, 0, 4'b0001, {18'd0, 6'd5}, 0);
        step('0, 0, '0, '0, 0);
        check("ovf_err", last_err, 1);
        for (int c = 0; c < 3; c++) step(4'b0001, 0, '0, '0, 0);
        check("sticky_err", last_err, 1);

        // Randomised traffic against the model.
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            logic [AW-1:0]    r;
            logic [RW-1:0]    rl;
            logic [RW*PW-1:0] rp;
            r  = AW'($urandom);
            rl = ($urandom_range(0, 2) == 0) ? RW'($urandom) : '0;
            rp = (AW*PW)'({$urandom, $urandom});
            step(r, ($urandom_range(0, 15) == 0), rl, rp, int'($urandom_range(0, 4)));
        end

        // Reset mid-stream restores the full list at once.
        step(4'b1111, 0, '0, '0, 0);
        apply_reset();
        step(4'b0001, 0, '0, '0, 0);
        check("post_rst_pidx", last_pidx[0*PW +: PW], 32);
        check("post_rst_free", last_free, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
